rpn_sequencer: RTL and testbench
================================

Name: rpn_sequencer

Overview:
- Program driver for the team's stack calculator; acts as the initiator on the calculator's op/in/apply interface.
- Holds a loadable program of up to DEPTH tokens (op + operand) and replays it on start, issuing one token per cycle.
- Monitors the calculator's valid/head outputs and reports the result, done and an error code, so upper layers never sequence the calculator directly.

Parameters:
W, 8, data width; must match the calculator's W
DEPTH, 16, program memory entries
AW, 4, program pointer width; requires 2^AW >= DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
prog_we  in  1  append token {prog_op, prog_data}; honoured only in IDLE
prog_op  in  4  token opcode (calculator encoding 0..8)
prog_data  in  W  operand; used by op 7 (push) only
prog_clr  in  1  clear program (count := 0); honoured only in IDLE
prog_full  out  1  count == DEPTH
start  in  1  run program; sampled only in IDLE
busy  out  1  high in CLR, ISSUE and WAIT
done  out  1  one-cycle pulse in DONE
result  out  W  calc_head latched on entry to DONE; held until next DONE
err_code  out  2  0 ok, 1 calculator invalid, 2 final depth != 1, 3 empty program; latched with result
calc_rst  out  1  to calculator rst (active-high); high in CLR and while rst is low
calc_op  out  4  token opcode
calc_in  out  W  token operand
calc_apply  out  1  high only in ISSUE
calc_head  in  W  calculator top of stack
calc_empty  in  1  calculator empty
calc_valid  in  1  calculator valid

Behaviour:
- Reset (rst low at clk edge): state IDLE, count 0, pc 0, shadow depth 0, result 0, err_code 0. busy, done and calc_apply are 0. calc_rst is 1.
- IDLE: prog_we with count < DEPTH writes mem[count] and increments count. prog_we when full is ignored; count is unchanged.
- IDLE: prog_clr takes priority over prog_we in the same cycle.
- IDLE: start with count == 0 goes to DONE with err_code 3 and result unchanged.
- IDLE: start with count > 0 goes to CLR, clears pc and shadow depth.
- IDLE: start in the same cycle as prog_we counts the newly written token.
- CLR (1 cycle): calc_rst=1, calc_apply=0, then ISSUE.
- ISSUE: calc_op/calc_in = mem[pc], calc_apply=1. Each cycle pc++ and the shadow depth updates:
  - op 7: +1
  - ops 2..6 and 8: -1, saturating at 0
  - ops 0, 1: unchanged
- ISSUE exits to WAIT after the cycle with pc == count-1.
- Early abort: in ISSUE, calc_valid==0 means the previous token failed. No token is issued that cycle (calc_apply=0), and the block goes to DONE with err_code 1.
- WAIT (1 cycle, calc_apply=0): lets the last token settle, then DONE. err_code is set as follows:
  - calc_valid==0: 1
  - else shadow depth != 1: 2
  - else: 0
- DONE (1 cycle): done=1, result=calc_head, then IDLE.
- The program is retained after a run, so start replays it.
- start, prog_we and prog_clr outside IDLE are ignored.
- Timing, counting the start-sample cycle as 0 with N tokens: cycle 1 CLR, cycles 2..N+1 ISSUE, cycle N+2 WAIT, cycle N+3 DONE.
- Arithmetic wraps modulo 2^W inside the calculator. The sequencer does not check operand widths.
- The sequencer does not check depth overflow beyond 11. The calculator's invalid flag reports it as err_code 1.
- Reset mid-run aborts immediately: the block returns to the reset state and the program is lost.

Test Plan:
- Load {7,6},{7,7},{4,x}, start at cycle 0 -> calc_apply high cycles 2-4, done at cycle 6, result 42, err_code 0.
- Load {7,5},{7,0},{5,x} -> division by zero; calc_valid low seen, done with err_code 1, calc_apply never high after the failing token.
- Load {7,3},{7,4} -> done at cycle 5, err_code 2, result 4.
- start with empty program -> done at cycle 1, err_code 3, busy never high. Also: write DEPTH+1 tokens -> prog_full=1, count stays DEPTH.
- Load {7,255},{0,x} -> result 0 (wrap), err_code 0. Then start again without reloading -> identical result 0.
- Drive rst low during ISSUE -> next cycle state IDLE, busy 0, calc_rst 1, prog_full 0, done never pulses.

Source files
------------

// File: rtl/rpn_sequencer.sv
// Program driver for the stack calculator: stores up to DEPTH {op, operand} tokens and
// replays them one per cycle, reporting result, done and an error code.
module rpn_sequencer #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         prog_we,
    input  logic [3:0]   prog_op,
    input  logic [W-1:0] prog_data,
    input  logic         prog_clr,
    output logic         prog_full,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [1:0]   err_code,
    output logic         calc_rst,
    output logic [3:0]   calc_op,
    output logic [W-1:0] calc_in,
    output logic         calc_apply,
    input  logic [W-1:0] calc_head,
    input  logic         calc_empty,
    input  logic         calc_valid
);

    typedef enum logic [2:0] {StIdle, StClr, StIssue, StWait, StDone} state_e;

    localparam logic [AW:0]   DepthC = (AW+1)'(DEPTH);
    localparam logic [AW:0]   One    = 1;
    localparam logic [AW-1:0] PcOne  = 1;

    state_e         state_q, state_d;
    logic [AW:0]    count_q, count_d;
    logic [AW:0]    depth_q, depth_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [W-1:0]   result_q, result_d;
    logic [1:0]     err_q, err_d;
    logic           mem_we;
    logic           last_tok;

    logic [3:0]     op_mem   [DEPTH];
    logic [W-1:0]   data_mem [DEPTH];

    // Emptiness is tracked by the shadow depth instead.
    logic unused_calc_empty;
    assign unused_calc_empty = calc_empty;

    assign calc_op   = op_mem[pc_q];
    assign calc_in   = data_mem[pc_q];
    assign prog_full = (count_q == DepthC);
    assign result    = result_q;
    assign err_code  = err_q;
    assign calc_rst  = !rst || (state_q == StClr);
    assign last_tok  = ({1'b0, pc_q} == count_q - One);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        depth_d    = depth_q;
        pc_d       = pc_q;
        result_d   = result_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        calc_apply = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (prog_clr) begin
                    count_d = '0;
                end else if (prog_we && !prog_full) begin
                    mem_we  = 1'b1;
                    count_d = count_q + One;
                end
                // count_d so a token written alongside start is part of the run
                if (start) begin
                    if (count_d == '0) begin
                        state_d = StDone;
                        err_d   = 2'd3;
                    end else begin
                        state_d = StClr;
                        pc_d    = '0;
                        depth_d = '0;
                    end
                end
            end
            StClr: begin
                busy    = 1'b1;
                state_d = StIssue;
            end
            StIssue: begin
                busy = 1'b1;
                if (!calc_valid) begin
                    state_d  = StDone;
                    err_d    = 2'd1;
                    result_d = calc_head;
                end else begin
                    calc_apply = 1'b1;
                    pc_d       = pc_q + PcOne;
                    case (calc_op)
                        4'd7: depth_d = depth_q + One;
                        4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8: begin
                            if (depth_q != '0) depth_d = depth_q - One;
                        end
                        default: depth_d = depth_q;
                    endcase
                    if (last_tok) state_d = StWait;
                end
            end
            StWait: begin
                busy     = 1'b1;
                state_d  = StDone;
                result_d = calc_head;
                if (!calc_valid)         err_d = 2'd1;
                else if (depth_q != One) err_d = 2'd2;
                else                     err_d = 2'd0;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            depth_q  <= '0;
            pc_q     <= '0;
            result_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            depth_q  <= depth_d;
            pc_q     <= pc_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            op_mem[count_q[AW-1:0]]   <= prog_op;
            data_mem[count_q[AW-1:0]] <= prog_data;
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench: behavioural stack calculator plus a program-level reference model.
module tb_rpn_sequencer;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MAXD  = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         prog_we, prog_clr, start;
    logic [3:0]   prog_op;
    logic [W-1:0] prog_data;
    logic         prog_full, busy, done, calc_rst, calc_apply;
    logic [W-1:0] result, calc_in, calc_head;
    logic [1:0]   err_code;
    logic [3:0]   calc_op;
    logic         calc_empty, calc_valid;

    always #5 clk = ~clk;

    rpn_sequencer #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_op(prog_op), .prog_data(prog_data),
        .prog_clr(prog_clr), .prog_full(prog_full), .start(start), .busy(busy), .done(done),
        .result(result), .err_code(err_code), .calc_rst(calc_rst), .calc_op(calc_op),
        .calc_in(calc_in), .calc_apply(calc_apply), .calc_head(calc_head),
        .calc_empty(calc_empty), .calc_valid(calc_valid)
    );

    typedef struct {
        logic [MAXD-1:0][W-1:0] d;
        int                     n;
        bit                     ok;
    } calc_t;

    function automatic calc_t calc_fresh();
        calc_t r;
        r.d  = '0;
        r.n  = 0;
        r.ok = 1'b1;
        return r;
    endfunction

    // Calculator semantics: 0 inc, 1 neg, 2 add, 3 sub, 4 mul, 5 div, 6 mod, 7 push, 8 drop.
    function automatic calc_t calc_step(calc_t c, logic [3:0] op, logic [W-1:0] v);
        calc_t        r;
        logic [W-1:0] a, b, y;
        r = c;
        if (!r.ok) return r;
        if (op > 4'd8) begin
            r.ok = 1'b0;
        end else if (op == 4'd7) begin
            if (r.n == MAXD) r.ok = 1'b0;
            else begin r.d[r.n] = v; r.n++; end
        end else if (op == 4'd0 || op == 4'd1 || op == 4'd8) begin
            if (r.n < 1) r.ok = 1'b0;
            else if (op == 4'd0) r.d[r.n-1] = r.d[r.n-1] + 8'd1;
            else if (op == 4'd1) r.d[r.n-1] = 8'd0 - r.d[r.n-1];
            else r.n--;
        end else begin
            if (r.n < 2) return calc_fresh_bad(r);
            a = r.d[r.n-2];
            b = r.d[r.n-1];
            if ((op == 4'd5 || op == 4'd6) && b == 0) return calc_fresh_bad(r);
            case (op)
                4'd2:    y = a + b;
                4'd3:    y = a - b;
                4'd4:    y = a * b;
                4'd5:    y = a / b;
                default: y = a % b;
            endcase
            r.d[r.n-2] = y;
            r.n--;
        end
        return r;
    endfunction

    function automatic calc_t calc_fresh_bad(calc_t c);
        calc_t r;
        r    = c;
        r.ok = 1'b0;
        return r;
    endfunction

    function automatic logic [W-1:0] head_of(calc_t c);
        return (c.n > 0) ? c.d[c.n-1] : '0;
    endfunction

    // Environment: the calculator the sequencer drives.
    calc_t cs;
    always @(posedge clk) begin
        if (calc_rst)        cs <= calc_fresh();
        else if (calc_apply) cs <= calc_step(cs, calc_op, calc_in);
    end
    assign calc_head  = head_of(cs);
    assign calc_empty = (cs.n == 0);
    assign calc_valid = cs.ok;

    logic [3:0]   p_op  [DEPTH];
    logic [W-1:0] p_dat [DEPTH];
    int           pn;
    logic [W-1:0] last_res;
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add_tok(input logic [3:0] op, input logic [W-1:0] v);
        p_op[pn]  = op;
        p_dat[pn] = v;
        pn++;
    endtask

    // Program-level expectation: done cycle, tokens applied, result, error.
    task automatic ref_run(output int e_done, output int e_apply,
                           output logic [W-1:0] e_res, output logic [1:0] e_err);
        calc_t c;
        bit    stopped;
        c       = calc_fresh();
        stopped = 1'b0;
        if (pn == 0) begin
            e_done  = 1;
            e_apply = 0;
            e_res   = last_res;
            e_err   = 2'd3;
        end else begin
            e_done  = pn + 3;
            e_apply = pn;
            for (int i = 0; i < pn; i++) begin
                if (!stopped) begin
                    if (!c.ok) begin
                        e_apply = i;
                        e_done  = i + 3;
                        stopped = 1'b1;
                    end else begin
                        c = calc_step(c, p_op[i], p_dat[i]);
                    end
                end
            end
            e_res = head_of(c);
            if (!c.ok)        e_err = 2'd1;
            else if (c.n != 1) e_err = 2'd2;
            else              e_err = 2'd0;
        end
    endtask

    task automatic load_prog(input int n);
        prog_clr = 1'b1;
        @(negedge clk);
        prog_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            prog_we   = 1'b1;
            prog_op   = p_op[i];
            prog_data = p_dat[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    // Called at a negedge; with_we writes the last token of p_* in the start cycle.
    task automatic run_check(input string tag, input bit with_we);
        int           e_done, e_apply, got_done, applies, first_ap;
        bit           busy_seen;
        logic [W-1:0] e_res;
        logic [1:0]   e_err;
        ref_run(e_done, e_apply, e_res, e_err);
        start = 1'b1;
        if (with_we) begin
            prog_we   = 1'b1;
            prog_op   = p_op[pn-1];
            prog_data = p_dat[pn-1];
        end
        @(negedge clk);
        start     = 1'b0;
        prog_we   = 1'b0;
        got_done  = -1;
        applies   = 0;
        first_ap  = -1;
        busy_seen = 1'b0;
        for (int k = 1; k <= 60 && got_done < 0; k++) begin
            if (busy) busy_seen = 1'b1;
            if (calc_apply) begin
                applies++;
                if (first_ap < 0) first_ap = k;
            end
            if (done) begin
                got_done = k;
                check({tag, "_result"}, 32'(result), 32'(e_res));
                check({tag, "_err"}, 32'(err_code), 32'(e_err));
            end
            @(negedge clk);
        end
        if (got_done < 0) check({tag, "_timeout"}, 0, 1);
        check({tag, "_done_cycle"}, got_done, e_done);
        check({tag, "_applies"}, applies, e_apply);
        check({tag, "_first_apply"}, first_ap, (e_apply > 0) ? 2 : -1);
        check({tag, "_busy_seen"}, 32'(busy_seen), (pn > 0) ? 1 : 0);
        check({tag, "_done_pulse"}, 32'(done), 0);
        last_res = e_res;
    endtask

    int done_cnt;

    initial begin
        rst = 1'b0; prog_we = 1'b0; prog_clr = 1'b0; start = 1'b0;
        prog_op = '0; prog_data = '0;
        pn = 0; last_res = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_apply", 32'(calc_apply), 0);
        check("rst_calc_rst", 32'(calc_rst), 1);
        check("rst_result", 32'(result), 0);
        check("rst_err", 32'(err_code), 0);
        check("rst_full", 32'(prog_full), 0);
        rst = 1'b1;
        @(negedge clk);

        pn = 0; add_tok(7, 6); add_tok(7, 7); add_tok(4, 0);
        load_prog(pn); run_check("mul42", 1'b0);

        pn = 0; add_tok(7, 5); add_tok(7, 0); add_tok(5, 0);
        load_prog(pn); run_check("divzero", 1'b0);

        pn = 0; add_tok(7, 3); add_tok(7, 4);
        load_prog(pn); run_check("depth2", 1'b0);

        pn = 0;
        load_prog(pn); run_check("empty", 1'b0);

        pn = 0; add_tok(7, 255); add_tok(0, 0);
        load_prog(pn); run_check("wrap", 1'b0);
        run_check("replay", 1'b0);

        pn = 0; add_tok(7, 5);
        load_prog(pn); add_tok(7, 9); run_check("we_start", 1'b1);

        pn = 0; add_tok(7, 1);
        load_prog(pn);
        prog_clr = 1'b1; prog_we = 1'b1; prog_op = 4'd7; prog_data = 8'd2;
        @(negedge clk);
        prog_clr = 1'b0; prog_we = 1'b0;
        pn = 0; run_check("clr_prio", 1'b0);

        // DEPTH+1 writes; the extra push must be dropped.
        pn = 0; add_tok(7, 1);
        for (int i = 1; i < DEPTH; i++) add_tok(0, 0);
        load_prog(pn);
        prog_we = 1'b1; prog_op = 4'd7; prog_data = 8'd9;
        @(negedge clk);
        prog_we = 1'b0;
        check("full_flag", 32'(prog_full), 1);
        run_check("full_run", 1'b0);

        for (int t = 0; t < 20; t++) begin
            pn = 0;
            for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++) begin
                if ($urandom_range(0, 1) == 0) add_tok(7, 8'($urandom));
                else add_tok(4'($urandom_range(0, 8)), 8'($urandom));
            end
            load_prog(pn);
            run_check($sformatf("rand%0d", t), 1'b0);
        end

        // Reset in the middle of ISSUE with a full program loaded.
        pn = 0; add_tok(7, 1);
        for (int i = 1; i < DEPTH; i++) add_tok(0, 0);
        load_prog(pn);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_in_issue", 32'(calc_apply), 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_calc_rst", 32'(calc_rst), 1);
        check("midrst_full", 32'(prog_full), 0);
        check("midrst_apply", 32'(calc_apply), 0);
        rst = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("midrst_no_done", done_cnt, 0);
        pn = 0; last_res = '0;
        run_check("midrst_lost", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
